// File: rtl/seq_buffer.sv
// Nucleotide sequence buffer: valid/ready load, registered random reads, forward/reverse replay stream.
// Optional macro SEQ_BUF_SYMCHK_EN rejects load symbols other than G, C, A, T and raises sym_err.
module seq_buffer #(
    parameter int                N       = 128,
    parameter int                SYM_W   = 3,
    parameter int                BitAddr = $clog2(N + 1),
    parameter logic [SYM_W-1:0]  G       = 3'b001,
    parameter logic [SYM_W-1:0]  C       = 3'b110,
    parameter logic [SYM_W-1:0]  A       = 3'b100,
    parameter logic [SYM_W-1:0]  T       = 3'b011
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load_valid,
    input  logic [SYM_W-1:0]   load_sym,
    input  logic               load_last,
    output logic               load_ready,
    output logic               loaded,
    output logic [BitAddr-1:0] len,
    input  logic               rd_en,
    input  logic [BitAddr-1:0] rd_addr,
    output logic [SYM_W-1:0]   rd_sym,
    output logic               rd_valid,
    output logic               rd_oob,
    input  logic               stream_start,
    input  logic               stream_rev,
    input  logic               stream_ready,
    output logic               stream_valid,
    output logic [SYM_W-1:0]   stream_sym,
    output logic [BitAddr-1:0] stream_idx,
    output logic               stream_done,
    output logic               sym_err
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [BitAddr-1:0] LEN_MAX = BitAddr'(N);
    localparam logic [BitAddr-1:0] ONE     = BitAddr'(1);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOAD   = 2'd1,
        READY  = 2'd2,
        STREAM = 2'd3
    } state_t;

    function automatic logic is_nucleotide(input logic [SYM_W-1:0] s);
        return (s == G) || (s == C) || (s == A) || (s == T);
    endfunction

    logic [SYM_W-1:0] mem [N];

    state_t             state_q, state_d;
    logic [BitAddr-1:0] len_q, len_d;
    logic               load_ready_q, load_ready_d;
    logic               loaded_q, loaded_d;
    logic               sym_err_q, sym_err_d;
    logic [SYM_W-1:0]   rd_sym_q, rd_sym_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_oob_q, rd_oob_d;
    logic               stream_valid_q, stream_valid_d;
    logic [SYM_W-1:0]   stream_sym_q, stream_sym_d;
    logic [BitAddr-1:0] str_idx_q, str_idx_d;
    logic [BitAddr-1:0] str_cnt_q, str_cnt_d;
    logic               str_rev_q, str_rev_d;
    logic               stream_done_q, stream_done_d;

    logic               load_acc;
    logic               sym_ok;
    logic               mem_we;
    logic               rd_fire;
    logic [BitAddr-1:0] len_inc;

    assign load_acc = load_valid && load_ready_q;

`ifdef SEQ_BUF_SYMCHK_EN
    assign sym_ok = is_nucleotide(load_sym);
`else
    assign sym_ok = 1'b1;
`endif

    assign mem_we  = load_acc && sym_ok && !clear;
    assign len_inc = len_q + BitAddr'(sym_ok);
    assign rd_fire = rd_en && !clear && ((state_q == READY) || (state_q == STREAM));

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        load_ready_d   = load_ready_q;
        loaded_d       = loaded_q;
        sym_err_d      = sym_err_q;
        stream_valid_d = stream_valid_q;
        stream_sym_d   = stream_sym_q;
        str_idx_d      = str_idx_q;
        str_cnt_d      = str_cnt_q;
        str_rev_d      = str_rev_q;
        stream_done_d  = 1'b0;

        if (clear) begin
            state_d        = EMPTY;
            len_d          = '0;
            load_ready_d   = 1'b1;
            loaded_d       = 1'b0;
            sym_err_d      = 1'b0;
            stream_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                EMPTY, LOAD: begin
                    if (load_acc) begin
                        if (!sym_ok) sym_err_d = 1'b1;
                        len_d = len_inc;
                        // A rejected last beat still ends the load; with nothing stored we fall back to EMPTY.
                        if (load_last || (len_inc == LEN_MAX)) begin
                            if (len_inc == '0) begin
                                state_d = EMPTY;
                            end else begin
                                state_d      = READY;
                                load_ready_d = 1'b0;
                                loaded_d     = 1'b1;
                            end
                        end else if (len_inc != '0) begin
                            state_d = LOAD;
                        end
                    end
                end
                READY: begin
                    if (stream_start) begin
                        state_d        = STREAM;
                        str_rev_d      = stream_rev;
                        str_idx_d      = stream_rev ? (len_q - ONE) : '0;
                        str_cnt_d      = len_q;
                        stream_valid_d = 1'b1;
                    end
                end
                STREAM: begin
                    if (stream_valid_q && stream_ready) begin
                        if (str_cnt_q == ONE) begin
                            state_d        = READY;
                            stream_valid_d = 1'b0;
                            stream_done_d  = 1'b1;
                        end else begin
                            str_cnt_d = str_cnt_q - ONE;
                            str_idx_d = str_rev_q ? (str_idx_q - ONE) : (str_idx_q + ONE);
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // Prefetch the symbol for the beat presented next cycle so stream_sym is a flop.
        if (stream_valid_d) stream_sym_d = mem[str_idx_d[IDX_W-1:0]];
    end

    always_comb begin
        rd_sym_d   = rd_sym_q;
        rd_oob_d   = rd_oob_q;
        rd_valid_d = 1'b0;
        if (rd_fire) begin
            rd_valid_d = 1'b1;
            if (rd_addr >= len_q) begin
                rd_oob_d = 1'b1;
                rd_sym_d = '0;
            end else begin
                rd_oob_d = 1'b0;
                rd_sym_d = mem[rd_addr[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[len_q[IDX_W-1:0]] <= load_sym;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= EMPTY;
            len_q          <= '0;
            load_ready_q   <= 1'b1;
            loaded_q       <= 1'b0;
            sym_err_q      <= 1'b0;
            rd_sym_q       <= '0;
            rd_valid_q     <= 1'b0;
            rd_oob_q       <= 1'b0;
            stream_valid_q <= 1'b0;
            stream_sym_q   <= '0;
            str_idx_q      <= '0;
            str_cnt_q      <= '0;
            str_rev_q      <= 1'b0;
            stream_done_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            load_ready_q   <= load_ready_d;
            loaded_q       <= loaded_d;
            sym_err_q      <= sym_err_d;
            rd_sym_q       <= rd_sym_d;
            rd_valid_q     <= rd_valid_d;
            rd_oob_q       <= rd_oob_d;
            stream_valid_q <= stream_valid_d;
            stream_sym_q   <= stream_sym_d;
            str_idx_q      <= str_idx_d;
            str_cnt_q      <= str_cnt_d;
            str_rev_q      <= str_rev_d;
            stream_done_q  <= stream_done_d;
        end
    end

    assign load_ready   = load_ready_q;
    assign loaded       = loaded_q;
    assign len          = len_q;
    assign rd_sym       = rd_sym_q;
    assign rd_valid     = rd_valid_q;
    assign rd_oob       = rd_oob_q;
    assign stream_valid = stream_valid_q;
    assign stream_sym   = stream_sym_q;
    assign stream_idx   = str_idx_q;
    assign stream_done  = stream_done_q;

`ifdef SEQ_BUF_SYMCHK_EN
    assign sym_err = sym_err_q;
`else
    assign sym_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_buffer.sv
// Directed self-checking bench for seq_buffer; inputs change 1 time unit after posedge, outputs checked there.
module tb_seq_buffer;

    localparam int N       = 128;
    localparam int SYM_W   = 3;
    localparam int BitAddr = $clog2(N + 1);

    localparam logic [2:0] SG = 3'b001;
    localparam logic [2:0] SC = 3'b110;
    localparam logic [2:0] SA = 3'b100;
    localparam logic [2:0] ST = 3'b011;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               clear = 1'b0;
    logic               load_valid = 1'b0;
    logic [SYM_W-1:0]   load_sym = '0;
    logic               load_last = 1'b0;
    logic               load_ready;
    logic               loaded;
    logic [BitAddr-1:0] len;
    logic               rd_en = 1'b0;
    logic [BitAddr-1:0] rd_addr = '0;
    logic [SYM_W-1:0]   rd_sym;
    logic               rd_valid;
    logic               rd_oob;
    logic               stream_start = 1'b0;
    logic               stream_rev = 1'b0;
    logic               stream_ready = 1'b0;
    logic               stream_valid;
    logic [SYM_W-1:0]   stream_sym;
    logic [BitAddr-1:0] stream_idx;
    logic               stream_done;
    logic               sym_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] gatgc [5];
    logic [2:0] codes [4];

    seq_buffer #(.N(N), .SYM_W(SYM_W)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .load_valid(load_valid), .load_sym(load_sym), .load_last(load_last),
        .load_ready(load_ready), .loaded(loaded), .len(len),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_sym(rd_sym),
        .rd_valid(rd_valid), .rd_oob(rd_oob),
        .stream_start(stream_start), .stream_rev(stream_rev), .stream_ready(stream_ready),
        .stream_valid(stream_valid), .stream_sym(stream_sym), .stream_idx(stream_idx),
        .stream_done(stream_done), .sym_err(sym_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beat(input logic [2:0] s, input logic last);
        load_valid = 1'b1;
        load_sym   = s;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic read_at(input logic [BitAddr-1:0] a, input logic [2:0] exp_sym,
                           input logic exp_oob, input string tag);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_sym"},   32'(rd_sym),   32'(exp_sym));
        chk({tag, "_oob"},   32'(rd_oob),   32'(exp_oob));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        gatgc[0] = SG; gatgc[1] = SA; gatgc[2] = ST; gatgc[3] = SG; gatgc[4] = SC;
        codes[0] = SG; codes[1] = SC; codes[2] = SA; codes[3] = ST;

        // Reset values
        step();
        step();
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_loaded",     32'(loaded),     32'd0);
        chk("rst_len",        32'(len),        32'd0);
        chk("rst_svalid",     32'(stream_valid), 32'd0);
        chk("rst_rvalid",     32'(rd_valid),   32'd0);
        chk("rst_sym_err",    32'(sym_err),    32'd0);
        rst = 1'b1;
        step();

        // Reads and stream_start in EMPTY are ignored
        rd_en = 1'b1; stream_start = 1'b1;
        step();
        rd_en = 1'b0; stream_start = 1'b0;
        chk("empty_rd_valid", 32'(rd_valid), 32'd0);
        chk("empty_svalid",   32'(stream_valid), 32'd0);

        // clear wins over a load beat
        clear = 1'b1;
        load_beat(SG, 1'b1);
        clear = 1'b0;
        chk("clr_beat_len",    32'(len),    32'd0);
        chk("clr_beat_loaded", 32'(loaded), 32'd0);

        // Load G,A,T,G,C
        for (int i = 0; i < 4; i++) load_beat(gatgc[i], 1'b0);
        chk("load4_len",    32'(len),    32'd4);
        chk("load4_loaded", 32'(loaded), 32'd0);
        load_beat(gatgc[4], 1'b1);
        chk("load5_len",    32'(len),        32'd5);
        chk("load5_loaded", 32'(loaded),     32'd1);
        chk("load5_ready",  32'(load_ready), 32'd0);

        // Random reads
        read_at(BitAddr'(3), SG, 1'b0, "rd3");
        step();
        chk("rd3_pulse", 32'(rd_valid), 32'd0);
        chk("rd3_hold",  32'(rd_sym),   32'(SG));
        read_at(BitAddr'(5), 3'd0, 1'b1, "rd5");
        read_at(BitAddr'(4), SC, 1'b0, "rd4");
        read_at(BitAddr'(0), SG, 1'b0, "rd0");

        // Reverse stream, consumer ready toggling 1,0,1,...
        stream_start = 1'b1; stream_rev = 1'b1;
        step();
        stream_start = 1'b0; stream_rev = 1'b0;
        begin
            int k = 0;
            int cyc = 0;
            while (k < 5 && cyc < 40) begin
                stream_ready = (cyc % 2 == 0);
                chk("rev_valid", 32'(stream_valid), 32'd1);
                chk("rev_sym",   32'(stream_sym),   32'(gatgc[4 - k]));
                chk("rev_idx",   32'(stream_idx),   32'(4 - k));
                chk("rev_done",  32'(stream_done),  32'd0);
                step();
                if (stream_ready) k++;
                cyc++;
            end
            chk("rev_beats", 32'(k), 32'd5);
        end
        stream_ready = 1'b0;
        chk("rev_done_pulse", 32'(stream_done),  32'd1);
        chk("rev_done_valid", 32'(stream_valid), 32'd0);
        step();
        chk("rev_done_low",  32'(stream_done), 32'd0);
        chk("rev_loaded",    32'(loaded),      32'd1);

        // Forward stream at full rate
        stream_start = 1'b1;
        step();
        stream_start = 1'b0;
        stream_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("fwd_valid", 32'(stream_valid), 32'd1);
            chk("fwd_sym",   32'(stream_sym),   32'(gatgc[k]));
            chk("fwd_idx",   32'(stream_idx),   32'(k));
            step();
        end
        stream_ready = 1'b0;
        chk("fwd_done", 32'(stream_done), 32'd1);
        step();

        // clear after two accepted stream beats
        stream_start = 1'b1;
        step();
        stream_start = 1'b0;
        stream_ready = 1'b1;
        step();
        step();
        chk("clr_mid_idx", 32'(stream_idx), 32'd2);
        do_clear();
        stream_ready = 1'b0;
        chk("clr_svalid",     32'(stream_valid), 32'd0);
        chk("clr_done",       32'(stream_done),  32'd0);
        chk("clr_len",        32'(len),          32'd0);
        chk("clr_load_ready", 32'(load_ready),   32'd1);
        chk("clr_loaded",     32'(loaded),       32'd0);
        step();
        chk("clr_done_later", 32'(stream_done),  32'd0);

        // Fill to N without load_last
        for (int i = 0; i < N - 1; i++) load_beat(codes[i % 4], 1'b0);
        chk("fill127_loaded", 32'(loaded), 32'd0);
        chk("fill127_len",    32'(len),    32'd127);
        load_beat(codes[(N - 1) % 4], 1'b0);
        chk("fill_loaded",     32'(loaded),     32'd1);
        chk("fill_len",        32'(len),        32'd128);
        chk("fill_load_ready", 32'(load_ready), 32'd0);
        load_beat(SA, 1'b1);
        chk("fill_extra_len", 32'(len), 32'd128);
        read_at(BitAddr'(127), codes[127 % 4], 1'b0, "fill_rd127");
        read_at(BitAddr'(64),  codes[64 % 4],  1'b0, "fill_rd64");
        read_at(BitAddr'(128), 3'd0, 1'b1, "fill_rd128");

        // Asynchronous reset mid-load
        do_clear();
        load_beat(SG, 1'b0);
        load_beat(SC, 1'b0);
        load_valid = 1'b1; load_sym = SA;
        #2;
        rst = 1'b0;
        #1;
        load_valid = 1'b0;
        chk("arst_len",        32'(len),        32'd0);
        chk("arst_load_ready", 32'(load_ready), 32'd1);
        chk("arst_loaded",     32'(loaded),     32'd0);
        step();
        rst = 1'b1;
        step();
        load_beat(ST, 1'b0);
        load_beat(SC, 1'b0);
        load_beat(SA, 1'b1);
        chk("reload_len",    32'(len),    32'd3);
        chk("reload_loaded", 32'(loaded), 32'd1);
        read_at(BitAddr'(2), SA, 1'b0, "reload_rd2");

        // Invalid symbol handling
        do_clear();
        load_beat(SG, 1'b0);
        load_beat(3'b111, 1'b0);
        load_beat(SA, 1'b1);
`ifdef SEQ_BUF_SYMCHK_EN
        chk("symchk_len",     32'(len),     32'd2);
        chk("symchk_err",     32'(sym_err), 32'd1);
        read_at(BitAddr'(1), SA, 1'b0, "symchk_rd1");
        chk("symchk_err_held", 32'(sym_err), 32'd1);
        do_clear();
        chk("symchk_err_clr", 32'(sym_err), 32'd0);
`else
        chk("nochk_len", 32'(len),     32'd3);
        chk("nochk_err", 32'(sym_err), 32'd0);
        read_at(BitAddr'(1), 3'b111, 1'b0, "nochk_rd1");
        read_at(BitAddr'(2), SA, 1'b0, "nochk_rd2");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
